// File: rtl/ring_meter_sched.sv
// Round-robin gated edge counter shared across ring-oscillator inputs; one channel per window.
// Optional channel masking is enabled by defining RING_METER_MASK_EN (adds chan_mask input).
module ring_meter_sched #(
  parameter int CHANNELS    = 4,
  parameter int GATE_CYCLES = 100,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         ring_in,
`ifdef RING_METER_MASK_EN
  input  logic [CHANNELS-1:0]         chan_mask,
`endif
  input  logic                        run,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [$clog2(CHANNELS)-1:0] result_chan,
  output logic [CNT_W-1:0]            result_value,
  output logic                        result_ovf,
  output logic                        busy
);

  localparam int CW = $clog2(CHANNELS);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [CHANNELS-1:0] sync1, sync2, sync3, pulse;
  logic [CHANNELS-1:0] enabled;
  logic [CW-1:0]       sel, next_sel;
  logic                next_found;
  logic [CW:0]         cand;
  logic [GW-1:0]       gate_cnt;
  logic [CNT_W-1:0]    edge_cnt, cnt_nxt;
  logic                edge_ovf, ovf_nxt;
  logic                cur_pulse;
  logic                win_start, win_done;

`ifdef RING_METER_MASK_EN
  assign enabled = chan_mask;
`else
  assign enabled = '1;
`endif

  // Per-channel synchronizer plus registered rising-edge detect: 3 cycles input to pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      pulse <= '0;
    end else begin
      sync1 <= ring_in;
      sync2 <= sync1;
      sync3 <= sync2;
      pulse <= sync2 & ~sync3;
    end
  end

  // First enabled channel strictly after sel, wrapping; sel resets to the last channel
  // so the first search starts at channel 0.
  always_comb begin
    next_sel   = '0;
    next_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = {1'b0, sel} + (CW+1)'(i);
      if (cand >= (CW+1)'(CHANNELS))
        cand = cand - (CW+1)'(CHANNELS);
      if (!next_found && enabled[cand[CW-1:0]]) begin
        next_found = 1'b1;
        next_sel   = cand[CW-1:0];
      end
    end
  end

  // Overflow means an edge arrived while the counter was already at its maximum.
  assign cur_pulse = pulse[sel];

  always_comb begin
    cnt_nxt = edge_cnt;
    ovf_nxt = edge_ovf;
    if (cur_pulse) begin
      if (edge_cnt == CNT_MAX)
        ovf_nxt = 1'b1;
      else
        cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run && next_found) state_nxt = GATE;
      GATE: if (gate_cnt == GW'(1)) state_nxt = HOLD;
      HOLD: if (result_ready) state_nxt = (run && next_found) ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    result_valid = (state == HOLD);
    busy         = (state != IDLE);
    win_start    = (state != GATE) && (state_nxt == GATE);
    win_done     = (state == GATE) && (gate_cnt == GW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel          <= CW'(CHANNELS - 1);
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      edge_ovf     <= 1'b0;
      result_chan  <= '0;
      result_value <= '0;
      result_ovf   <= 1'b0;
    end else begin
      if (win_start) begin
        sel      <= next_sel;
        gate_cnt <= GW'(GATE_CYCLES);
        edge_cnt <= '0;
        edge_ovf <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt - GW'(1);
        edge_cnt <= cnt_nxt;
        edge_ovf <= ovf_nxt;
      end
      if (win_done) begin
        result_value <= cnt_nxt;
        result_ovf   <= ovf_nxt;
        result_chan  <= sel;
      end
    end
  end

endmodule
